// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares one single-port, fixed-latency (1 cycle) SRAM between the pipeline's
// instruction-fetch requester (inst_*) and data-access requester (data_*).
// Data wins contention. A saturating streak counter bounds how long fetch can
// be starved: after MAX_DATA_BURST consecutive contended data grants, fetch
// is forced through. Every granted read is tagged so that the returning SRAM
// data is steered to the requester that issued it one cycle later.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   inst_req/we/addr/wdata     fetch request (we == 0 means read)
//   inst_gnt                   fetch accepted this cycle (combinational)
//   inst_rvalid/inst_rdata     fetch read response (cycle after grant)
//   data_*                     same group for the data requester
//   mem_en/we/addr/wdata       SRAM command, all zero when idle
//   mem_rdata                  SRAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [DATA_W/8-1:0] inst_we,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    // Consecutive contended data grants since fetch was last served/idle.
    logic [STREAK_W-1:0] streak_q, streak_d;
    // One-cycle response tags for reads issued in the previous cycle.
    logic                rd_inst_q, rd_inst_d;
    logic                rd_data_q, rd_data_d;

    logic                inst_win;
    logic                data_win;

    // -----------------------------------------------------------------------
    // Arbitration. Depends only on req inputs, rst and the streak register,
    // so there is no path from mem_rdata to either grant.
    // -----------------------------------------------------------------------
    always_comb begin
        inst_win = 1'b0;
        data_win = 1'b0;
        if (!rst) begin
            if (inst_req && data_req) begin
                if (streak_q == STREAK_MAX) begin
                    inst_win = 1'b1;
                end else begin
                    data_win = 1'b1;
                end
            end else if (inst_req) begin
                inst_win = 1'b1;
            end else if (data_req) begin
                data_win = 1'b1;
            end
        end
    end

    assign inst_gnt = inst_win;
    assign data_gnt = data_win;
    assign mem_en   = inst_win | data_win;

    // -----------------------------------------------------------------------
    // SRAM command mux. The winners are one-hot (or both zero), so an AND-OR
    // mux both selects the winner and zeroes the bus when idle.
    // -----------------------------------------------------------------------
    assign mem_addr = ({ADDR_W{inst_win}} & inst_addr)
                    | ({ADDR_W{data_win}} & data_addr);

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            assign mem_we[gi] = (inst_win & inst_we[gi])
                              | (data_win & data_we[gi]);
            assign mem_wdata[gi*8 +: 8] = ({8{inst_win}} & inst_wdata[gi*8 +: 8])
                                        | ({8{data_win}} & data_wdata[gi*8 +: 8]);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic for the streak counter and response tags.
    // The counter only grows while fetch is actually waiting; it can never
    // exceed STREAK_MAX because at STREAK_MAX contention goes to fetch.
    // -----------------------------------------------------------------------
    always_comb begin
        streak_d = streak_q;
        if (!inst_req || inst_win) begin
            streak_d = '0;
        end else if (data_win && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end

        rd_inst_d = inst_win && (inst_we == '0);
        rd_data_d = data_win && (data_we == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q  <= '0;
            rd_inst_q <= 1'b0;
            rd_data_q <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            rd_inst_q <= rd_inst_d;
            rd_data_q <= rd_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Response steering. Responses are masked while rst is high so that a
    // read issued just before reset never surfaces.
    // -----------------------------------------------------------------------
    assign inst_rvalid = rd_inst_q & ~rst;
    assign data_rvalid = rd_data_q & ~rst;
    assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
    assign data_rdata  = data_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. Each step drives inputs after the
// falling edge, checks all outputs against a behavioural reference model
// shortly after, then advances the model at the rising edge. Directed
// scenarios are followed by randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req,  data_req;
    logic [7:0]    inst_we,   data_we;
    logic [AW-1:0] inst_addr, data_addr;
    logic [DW-1:0] inst_wdata, data_wdata;
    logic          inst_gnt,  data_gnt;
    logic          inst_rvalid, data_rvalid;
    logic [DW-1:0] inst_rdata, data_rdata;
    logic          mem_en;
    logic [7:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAX)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_we(inst_we), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: how many data grants fetch has lost in a row,
    // and which requester (if any) owns the response arriving next cycle.
    int m_streak = 0;
    bit m_pend_i = 0;
    bit m_pend_d = 0;

    // Snapshot of DUT outputs from the most recent step.
    logic          s_ignt, s_dgnt, s_irv, s_drv;
    logic [DW-1:0] s_drdata, s_mem_wdata;
    logic [7:0]    s_mem_we;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r,
                        input bit ir, input logic [7:0] iwe, input logic [63:0] ia, input logic [63:0] iwd,
                        input bit dr, input logic [7:0] dwe, input logic [63:0] da, input logic [63:0] dwd,
                        input logic [63:0] mrd);
        int g;
        logic [7:0]  e_we;
        logic [63:0] e_addr, e_wd;
        bit ev_i, ev_d;
        @(negedge clk);
        rst = r;
        inst_req = ir; inst_we = iwe; inst_addr = ia; inst_wdata = iwd;
        data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
        mem_rdata = mrd;
        #1;
        // 0 = no grant, 1 = fetch, 2 = data
        g = 0;
        if (!r) begin
            if (ir && dr)  g = (m_streak >= MAX) ? 1 : 2;
            else if (ir)   g = 1;
            else if (dr)   g = 2;
        end
        e_we   = (g == 1) ? iwe : (g == 2) ? dwe : 8'h00;
        e_addr = (g == 1) ? ia  : (g == 2) ? da  : 64'h0;
        e_wd   = (g == 1) ? iwd : (g == 2) ? dwd : 64'h0;
        ev_i   = !r && m_pend_i;
        ev_d   = !r && m_pend_d;
        chk("inst_gnt",    inst_gnt,    64'(g == 1));
        chk("data_gnt",    data_gnt,    64'(g == 2));
        chk("mem_en",      mem_en,      64'(g != 0));
        chk("mem_we",      mem_we,      e_we);
        chk("mem_addr",    mem_addr,    e_addr);
        chk("mem_wdata",   mem_wdata,   e_wd);
        chk("inst_rvalid", inst_rvalid, 64'(ev_i));
        chk("data_rvalid", data_rvalid, 64'(ev_d));
        chk("inst_rdata",  inst_rdata,  ev_i ? mrd : 64'h0);
        chk("data_rdata",  data_rdata,  ev_d ? mrd : 64'h0);
        s_ignt = inst_gnt; s_dgnt = data_gnt;
        s_irv = inst_rvalid; s_drv = data_rvalid; s_drdata = data_rdata;
        s_mem_we = mem_we; s_mem_wdata = mem_wdata;
        $display("t=%0t rst=%0d ireq=%0d dreq=%0d gnt=%0d ig=%0d dg=%0d irv=%0d drv=%0d",
                 $time, r, ir, dr, g, inst_gnt, data_gnt, inst_rvalid, data_rvalid);
        @(posedge clk);
        if (r) begin
            m_streak = 0; m_pend_i = 0; m_pend_d = 0;
        end else begin
            m_pend_i = (g == 1) && (iwe == 8'h00);
            m_pend_d = (g == 2) && (dwe == 8'h00);
            if (!ir || g == 1)  m_streak = 0;
            else if (g == 2)    m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
        end
    endtask

    task automatic idle(input logic [63:0] mrd);
        step(0, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h0, mrd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            hi_req, r;
        logic [7:0]    hi_we, d_we;
        logic [63:0]   hi_addr, hi_wd;
        int            iwait;

        rst = 1'b1;
        inst_req = 0; data_req = 0; inst_we = 0; data_we = 0;
        inst_addr = 0; data_addr = 0; inst_wdata = 0; data_wdata = 0; mem_rdata = 0;

        // Reset held with both requesters active; first cycle after goes to data.
        step(1, 1, 8'h00, 64'h100, 64'h0, 1, 8'h00, 64'h200, 64'h0, 64'h55);
        step(1, 1, 8'h00, 64'h100, 64'h0, 1, 8'h00, 64'h200, 64'h0, 64'h55);
        chk("reset_no_gnt", {s_ignt, s_dgnt}, 64'h0);
        step(0, 1, 8'h00, 64'h100, 64'h0, 1, 8'h00, 64'h200, 64'h0, 64'h0);
        chk("post_reset_data_first", s_dgnt, 64'h1);
        idle(64'h0);
        idle(64'h0);

        // Solo data read.
        step(0, 0, 8'h00, 64'h0, 64'h0, 1, 8'h00, 64'h80, 64'h0, 64'h0);
        chk("solo_read_gnt", s_dgnt, 64'h1);
        idle(64'hDEADBEEF);
        chk("solo_read_rdata", s_drdata, 64'hDEADBEEF);
        chk("solo_read_no_irv", s_irv, 64'h0);

        // Starvation guard: D,D,D,D,I repeating over 12 contended cycles.
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 8'h00, 64'h300, 64'h0, 1, 8'h00, 64'h400, 64'h0, 64'(k));
            chk($sformatf("starve_inst_gnt_c%0d", k + 1), s_ignt, 64'((k % 5) == 4));
        end
        idle(64'h0);
        idle(64'h0);

        // Fetch write routing.
        step(0, 1, 8'hFF, 64'h10, 64'h1234, 0, 8'h00, 64'h0, 64'h0, 64'h0);
        chk("write_mem_we", s_mem_we, 64'hFF);
        chk("write_mem_wdata", s_mem_wdata, 64'h1234);
        idle(64'hABCD);
        chk("write_no_irv", s_irv, 64'h0);

        // Back-to-back mixed traffic.
        step(0, 0, 8'h00, 64'h0, 64'h0, 1, 8'h00, 64'h500, 64'h0, 64'h0);
        step(0, 1, 8'h00, 64'h600, 64'h0, 0, 8'h00, 64'h0, 64'h0, 64'h11);
        chk("b2b_c1", {s_irv, s_drv}, 64'h1);
        step(0, 0, 8'h00, 64'h0, 64'h0, 1, 8'h0F, 64'h700, 64'h99, 64'h22);
        chk("b2b_c2", {s_irv, s_drv}, 64'h2);
        idle(64'h33);
        chk("b2b_c3", {s_irv, s_drv}, 64'h0);

        // Mid-operation reset with a partially built streak.
        step(0, 1, 8'h00, 64'h800, 64'h0, 1, 8'h00, 64'h900, 64'h0, 64'h0);
        step(0, 1, 8'h00, 64'h800, 64'h0, 1, 8'h00, 64'h900, 64'h0, 64'h0);
        step(0, 1, 8'h00, 64'h800, 64'h0, 1, 8'h00, 64'h908, 64'h0, 64'h0);
        step(1, 0, 8'h00, 64'h0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 64'h77);
        chk("midrst_rvalid_c1", s_drv, 64'h0);
        idle(64'h88);
        chk("midrst_rvalid_c2", s_drv, 64'h0);
        chk("midrst_streak", 64'(dut.streak_q), 64'h0);

        // Randomized traffic; fetch holds its request until granted.
        hi_req = 0; hi_we = 0; hi_addr = 0; hi_wd = 0; iwait = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!hi_req) begin
                hi_req  = ($urandom_range(0, 99) < 60);
                hi_we   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                hi_addr = {$urandom, $urandom};
                hi_wd   = {$urandom, $urandom};
            end
            r    = ($urandom_range(0, 99) == 0);
            d_we = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            step(r, hi_req, hi_we, hi_addr, hi_wd,
                 ($urandom_range(0, 99) < 75), d_we, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom});
            if (r) begin
                iwait = 0;
            end else if (hi_req) begin
                if (s_ignt) begin
                    chk("inst_wait_bound", 64'(iwait <= MAX), 64'h1);
                    iwait  = 0;
                    hi_req = 0;
                end else begin
                    iwait++;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
